// File: rtl/cube_pkg.sv
// Cube geometry shared by the sticker fetch block and its neighbours.
// Facelets are numbered face*9 + row*3 + col, with faces in U,R,F,D,L,B order.
package cube_pkg;

    localparam int unsigned COLOR_W      = 3;
    localparam int unsigned NUM_FACELETS = 54;
    localparam int unsigned NUM_PIECES   = 24;
    localparam int unsigned IDX_W        = 5;
    localparam int unsigned FACELET_W    = $clog2(NUM_FACELETS);

    localparam int unsigned FACE_U = 0;
    localparam int unsigned FACE_R = 1;
    localparam int unsigned FACE_F = 2;
    localparam int unsigned FACE_D = 3;
    localparam int unsigned FACE_L = 4;
    localparam int unsigned FACE_B = 5;

    // Facelet number of a (face,row,col) position.
    function automatic logic [FACELET_W-1:0] facelet_num(input int unsigned face,
                                                         input int unsigned row,
                                                         input int unsigned col);
        return FACELET_W'(face * 9 + row * 3 + col);
    endfunction

    // Corner stickers in learning order: D four, then B, R, F, L, U.
    // Within a face the order is top-left, top-right, bottom-left, bottom-right.
    localparam logic [FACELET_W-1:0] CORNER_POS [24] = '{
        6'd27, 6'd29, 6'd33, 6'd35,   // D
        6'd45, 6'd47, 6'd51, 6'd53,   // B
        6'd9,  6'd11, 6'd15, 6'd17,   // R
        6'd18, 6'd20, 6'd24, 6'd26,   // F
        6'd36, 6'd38, 6'd42, 6'd44,   // L
        6'd0,  6'd2,  6'd6,  6'd8     // U
    };

    // Edge stickers in the same face order: top, left, right, bottom of each face.
    localparam logic [FACELET_W-1:0] EDGE_POS [24] = '{
        6'd28, 6'd30, 6'd32, 6'd34,   // D
        6'd46, 6'd48, 6'd50, 6'd52,   // B
        6'd10, 6'd12, 6'd14, 6'd16,   // R
        6'd19, 6'd21, 6'd23, 6'd25,   // F
        6'd37, 6'd39, 6'd41, 6'd43,   // L
        6'd1,  6'd3,  6'd5,  6'd7     // U
    };

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StExtract,
        StEmit
    } fetch_state_e;

endpackage

// File: rtl/sticker_fetch_if.sv
// Request/response handshake bundle between a requester and sticker_fetch.
interface sticker_fetch_if #(
    parameter int unsigned COLOR_W = cube_pkg::COLOR_W,
    parameter int unsigned IDX_W   = cube_pkg::IDX_W
) ();

    logic               req_valid;
    logic               req_ready;
    logic               req_kind;
    logic               req_sweep;
    logic [IDX_W-1:0]   req_index;

    logic               out_valid;
    logic               out_ready;
    logic [COLOR_W-1:0] out_color;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;
    logic               out_err;

    // Requester side: issues requests and consumes responses.
    modport master (
        output req_valid, req_kind, req_sweep, req_index, out_ready,
        input  req_ready, out_valid, out_color, out_index, out_last, out_err
    );

    // Fetch block side.
    modport slave (
        input  req_valid, req_kind, req_sweep, req_index, out_ready,
        output req_ready, out_valid, out_color, out_index, out_last, out_err
    );

endinterface

// File: rtl/sticker_rom.sv
// Registered piece-to-facelet table read. Indices past the table select
// facelet 0 and raise out_of_range so the caller can flag the response.
module sticker_rom #(
    parameter int unsigned IDX_W      = cube_pkg::IDX_W,
    parameter int unsigned NUM_PIECES = cube_pkg::NUM_PIECES
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           kind,
    input  logic [IDX_W-1:0]               index,
    output logic [cube_pkg::FACELET_W-1:0] facelet,
    output logic                           out_of_range
);

    import cube_pkg::*;

    logic [FACELET_W-1:0] facelet_d;
    logic                 oor_d;

    // Table lookup; the index is only applied to the tables once range-checked.
    always_comb begin
        facelet_d = '0;
        oor_d     = 1'b1;
        if (32'(index) < NUM_PIECES) begin
            oor_d     = 1'b0;
            facelet_d = kind ? EDGE_POS[index] : CORNER_POS[index];
        end
    end

    // Result register, loaded only in the lookup cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            facelet      <= '0;
            out_of_range <= 1'b0;
        end else if (enable) begin
            facelet      <= facelet_d;
            out_of_range <= oor_d;
        end
    end

endmodule

// File: rtl/sticker_fetch.sv
// Sticker colour fetch: snapshots the packed cube state on request acceptance
// and returns corner or edge sticker colours, one piece or a full sweep, over
// valid/ready handshakes. Each sticker costs lookup, extract and emit cycles.
module sticker_fetch #(
    parameter int unsigned COLOR_W      = cube_pkg::COLOR_W,
    parameter int unsigned NUM_FACELETS = cube_pkg::NUM_FACELETS,
    parameter int unsigned NUM_PIECES   = cube_pkg::NUM_PIECES,
    parameter int unsigned IDX_W        = cube_pkg::IDX_W
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [COLOR_W*NUM_FACELETS-1:0] cubestate,
    sticker_fetch_if.slave                  bus
);

    import cube_pkg::*;

    fetch_state_e state_q, state_d;

    logic [COLOR_W*NUM_FACELETS-1:0] snapshot_q, snapshot_d;
    logic                            kind_q, kind_d;
    logic                            sweep_q, sweep_d;
    logic [IDX_W-1:0]                idx_q, idx_d;

    logic                            out_valid_q, out_valid_d;
    logic [COLOR_W-1:0]              out_color_q, out_color_d;
    logic [IDX_W-1:0]                out_index_q, out_index_d;
    logic                            out_last_q, out_last_d;
    logic                            out_err_q, out_err_d;

    logic                            rom_enable;
    logic [FACELET_W-1:0]            rom_facelet;
    logic                            rom_oor;

    logic [COLOR_W-1:0]              facelet_color [NUM_FACELETS];

    sticker_rom #(
        .IDX_W      (IDX_W),
        .NUM_PIECES (NUM_PIECES)
    ) u_rom (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (rom_enable),
        .kind         (kind_q),
        .index        (idx_q),
        .facelet      (rom_facelet),
        .out_of_range (rom_oor)
    );

    // View the snapshot as an array of facelet colours for indexed extraction.
    always_comb begin
        for (int f = 0; f < int'(NUM_FACELETS); f++) begin
            facelet_color[f] = snapshot_q[COLOR_W*f +: COLOR_W];
        end
    end

    // Next-state and datapath control for the fetch sequence.
    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        kind_d      = kind_q;
        sweep_d     = sweep_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_color_d = out_color_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        rom_enable  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    snapshot_d = cubestate;
                    kind_d     = bus.req_kind;
                    sweep_d    = bus.req_sweep;
                    idx_d      = bus.req_sweep ? '0 : bus.req_index;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                rom_enable = 1'b1;
                state_d    = StExtract;
            end
            StExtract: begin
                out_color_d = facelet_color[rom_facelet];
                out_index_d = idx_q;
                out_err_d   = rom_oor;
                // A sweep ends at the last table entry and never wraps.
                out_last_d  = !sweep_q || (32'(idx_q) == NUM_PIECES - 1);
                out_valid_d = 1'b1;
                state_d     = StEmit;
            end
            StEmit: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StLookup;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, snapshot and response registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            snapshot_q  <= '0;
            kind_q      <= 1'b0;
            sweep_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_color_q <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            kind_q      <= kind_d;
            sweep_q     <= sweep_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_color_q <= out_color_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_color = out_color_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_sticker_fetch.sv
// Scoreboard bench for sticker_fetch: expected responses are queued when a
// request is issued and compared in order as responses are handshaken.
module tb_sticker_fetch;

    import cube_pkg::*;

    localparam int unsigned CS_W = COLOR_W * NUM_FACELETS;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [IDX_W-1:0]   index;
        logic               last;
        logic               err;
    } resp_t;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [CS_W-1:0] cubestate = '0;

    sticker_fetch_if bus ();

    sticker_fetch dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cubestate (cubestate),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    resp_t exp_q[$];
    bit    ready_due = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference response for one piece of the given table.
    function automatic resp_t model(input logic [CS_W-1:0] cs, input logic kind,
                                    input logic [IDX_W-1:0] idx, input logic last);
        resp_t       r;
        int unsigned f;
        if (32'(idx) >= NUM_PIECES) begin
            f     = 0;
            r.err = 1'b1;
        end else begin
            f     = kind ? 32'(EDGE_POS[idx]) : 32'(CORNER_POS[idx]);
            r.err = 1'b0;
        end
        r.color = cs[COLOR_W*f +: COLOR_W];
        r.index = idx;
        r.last  = last;
        return r;
    endfunction

    // Response monitor: compare each handshaken response against the queue head.
    always @(negedge clock) begin
        resp_t e;
        if (ready_due) begin
            check_eq("ready_after_last", 32'(bus.req_ready), 32'd1);
            ready_due = 1'b0;
        end
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("color", 32'(bus.out_color), 32'(e.color));
                check_eq("index", 32'(bus.out_index), 32'(e.index));
                check_eq("last",  32'(bus.out_last),  32'(e.last));
                check_eq("err",   32'(bus.out_err),   32'(e.err));
                if (e.last) ready_due = 1'b1;
            end
        end
    end

    // Issue one request and queue its expected responses; returns 1ns after acceptance.
    task automatic send_req(input logic kind, input logic sweep, input logic [IDX_W-1:0] index);
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!bus.req_ready) check_eq("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_sweep = sweep;
        bus.req_index = index;
        if (sweep) begin
            for (int i = 0; i < int'(NUM_PIECES); i++) begin
                exp_q.push_back(model(cubestate, kind, IDX_W'(i), i == int'(NUM_PIECES) - 1));
            end
        end else begin
            exp_q.push_back(model(cubestate, kind, index, 1'b1));
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_index = IDX_W'($urandom_range(0, 31));
    endtask

    // Wait until all queued responses are consumed and the block is idle again.
    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_state();
        for (int f = 0; f < int'(NUM_FACELETS); f++) begin
            cubestate[COLOR_W*f +: COLOR_W] = COLOR_W'($urandom_range(0, 6));
        end
    endtask

    initial begin
        int    n;
        logic  seen;
        logic [COLOR_W-1:0] held_color;

        bus.req_valid = 1'b0;
        bus.req_kind  = 1'b0;
        bus.req_sweep = 1'b0;
        bus.req_index = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset state.
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_color", 32'(bus.out_color), 32'd0);
        check_eq("rst_out_index", 32'(bus.out_index), 32'd0);
        check_eq("rst_out_last",  32'(bus.out_last),  32'd0);
        check_eq("rst_out_err",   32'(bus.out_err),   32'd0);

        // Single corner 0 with only its facelet coloured, plus latency.
        cubestate = '0;
        cubestate[COLOR_W*CORNER_POS[0] +: COLOR_W] = 3'd5;
        send_req(1'b0, 1'b0, 5'd0);
        check_eq("lat_after_e0", 32'(bus.out_valid), 32'd0);
        @(posedge clock); #1;
        check_eq("lat_after_e1", 32'(bus.out_valid), 32'd0);
        @(posedge clock); #1;
        check_eq("lat_after_e2", 32'(bus.out_valid), 32'd1);
        check_eq("corner0_color", 32'(bus.out_color), 32'd5);
        wait_drain(50);

        // Edge sweep, facelet f coloured f mod 8, with throughput check.
        for (int f = 0; f < int'(NUM_FACELETS); f++) begin
            cubestate[COLOR_W*f +: COLOR_W] = COLOR_W'(f % 8);
        end
        send_req(1'b1, 1'b1, 5'd17);
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("sweep_cycles", 32'(n), 32'(3 * NUM_PIECES));
        wait_drain(50);

        // Backpressure at index 7 of a corner sweep.
        random_state();
        send_req(1'b0, 1'b1, 5'd0);
        n = 0;
        while (!(bus.out_valid && bus.out_index == 5'd7) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("bp_found_idx7", 32'(bus.out_index), 32'd7);
        bus.out_ready = 1'b0;
        held_color = bus.out_color;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            check_eq("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check_eq("bp_color_held", 32'(bus.out_color), 32'(held_color));
            check_eq("bp_index_held", 32'(bus.out_index), 32'd7);
        end
        bus.out_ready = 1'b1;
        wait_drain(200);

        // cubestate overwritten the cycle after acceptance.
        random_state();
        send_req(1'b1, 1'b1, 5'd0);
        cubestate = '1;
        wait_drain(200);

        // Out-of-range single request.
        random_state();
        send_req(1'b0, 1'b0, 5'd30);
        cubestate = '1;
        wait_drain(50);

        // Reset while a response is stalled in EMIT.
        random_state();
        bus.out_ready = 1'b0;
        send_req(1'b1, 1'b0, 5'd9);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("midrst_out_color", 32'(bus.out_color), 32'd0);
        check_eq("midrst_out_last",  32'(bus.out_last),  32'd0);
        exp_q.delete();
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            seen = seen | bus.out_valid;
        end
        check_eq("no_resp_after_rst", 32'(seen), 32'd0);

        // A normal request still works after the abandoned one.
        random_state();
        send_req(1'b1, 1'b0, 5'd23);
        wait_drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sticker_fetch.md
Name: sticker_fetch

Overview:
- Parametrised successor to the corner-offset lookup. Returns the actual sticker colour from the packed cube state, not a bit offset.
- Serves corners and edges, in single-piece or full-sweep mode, behind valid/ready handshakes on request and response.
- Snapshots the cube state at request acceptance, so the solver's state register may change mid-sweep.
- Sits between the cube-state register and the solver/learning FSMs.

Parameters:
- COLOR_W, 3, bits per facelet colour code.
- NUM_FACELETS, 54, facelets in packed state; facelet f occupies cubestate[COLOR_W*f +: COLOR_W].
- NUM_PIECES, 24, stickers per kind (corner or edge) in learning order.
- IDX_W, 5, width of piece index (>= clog2(NUM_PIECES)).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- cubestate  in  COLOR_W*NUM_FACELETS  packed facelet colours.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_kind  in  1  0 = corner table, 1 = edge table.
- req_sweep  in  1  0 = single index, 1 = sweep indices 0..NUM_PIECES-1.
- req_index  in  IDX_W  piece index for single mode; ignored in sweep.
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts response.
- out_color  out  COLOR_W  sticker colour.
- out_index  out  IDX_W  piece index this colour belongs to.
- out_last  out  1  final response of the request.
- out_err  out  1  single-mode index >= NUM_PIECES.

Behaviour:
- Reset (reset_n low at a clock edge) forces:
  - state IDLE, req_ready=1;
  - out_valid, out_last, out_err = 0; out_color, out_index = 0;
  - snapshot register = 0.
- Reset mid-request: the request is abandoned immediately and no further response is produced.
- FSM states IDLE, LOOKUP, EXTRACT, EMIT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch cubestate into the snapshot, latch kind/sweep/index (sweep starts at index 0), go to LOOKUP.
- LOOKUP:
  - Registered ROM read: facelet number = CORNER_POS[idx] or EDGE_POS[idx].
  - Index >= NUM_PIECES selects facelet 0 and sets the pending error flag.
  - Go to EXTRACT.
- EXTRACT:
  - Register snapshot[COLOR_W*facelet +: COLOR_W] into out_color.
  - Set out_index, out_err, and out_last (single mode, or sweep idx == NUM_PIECES-1).
  - Assert out_valid; go to EMIT.
- EMIT:
  - Outputs held stable while out_valid && !out_ready.
  - On handshake with out_last=1: deassert out_valid, go to IDLE.
  - On handshake with out_last=0: idx+1, deassert out_valid, go to LOOKUP.
- Latency:
  - Request accepted at edge 0 -> out_valid high after edge 2 (first responses visible in cycle 3 relative to acceptance).
  - Sweep throughput: one sticker per 3 cycles with out_ready held high.
- req_ready is 0 in all states but IDLE. A request cannot be accepted in the same cycle as the final handshake; it is accepted on the next cycle.
- out_err is only meaningful with out_valid. An erroring request returns a single response with out_last=1 and out_color = snapshot facelet 0.
- Sweep never wraps: index NUM_PIECES-1 is always last. Index arithmetic is IDX_W bits; sweep never reaches overflow.
- cubestate changes after acceptance have no effect on the in-flight request.

Decomposition:
- Package cube_pkg holds:
  - constants COLOR_W, NUM_FACELETS, NUM_PIECES;
  - facelet numbering (face*9 + row*3 + col, face order U,R,F,D,L,B);
  - CORNER_POS[0:23] and EDGE_POS[0:23] tables in learning order (corners: D-face four, B, R, F, L, U);
  - enum for FSM states.
- One natural sub-module: sticker_rom (registered table read, kind+index -> facelet number, out-of-range flag). The FSM and extraction stay in sticker_fetch.

Test Plan:
- Reset during EMIT with out_ready=0 -> next cycle out_valid=0, req_ready=1, out_color=0; no further responses.
- Single corner idx 0:
  - stimulus: cubestate with only facelet CORNER_POS[0] = 3'd5, all others 0;
  - out_valid rises after 2 edges;
  - out_color=5, out_index=0, out_last=1, out_err=0.
- Edge sweep with out_ready=1, snapshot facelet f = f mod 8:
  - 24 responses;
  - response i has out_color = EDGE_POS[i] mod 8, out_index = i;
  - out_last only on i=23; req_ready returns to 1 the cycle after.
- Backpressure: sweep with out_ready low for 5 cycles at index 7 -> out_color/out_index/out_valid stable for all 5 cycles; index 7 is neither skipped nor repeated.
- cubestate changed to all-ones one cycle after acceptance -> every response of the sweep still reflects the snapshot.
- Single corner req_index=30 -> one response with out_err=1, out_last=1, out_color = snapshot facelet 0.
